pipe_adder_nb: RTL
==================

PIPE_ADDER_NB -- requirements
Module: pipe_adder_nb

Interface
REQ-001 SHALL have parameter N, default 16, the operand and sum width in bits.
REQ-002 SHALL have parameter STAGES, default 4, the number of register stages; legal when 1 <= STAGES <= N and N % STAGES == 0.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have ports in_valid (input, 1) and in_ready (output, 1): the upstream handshake.
REQ-006 SHALL have ports a and b (input, N): the operands.
REQ-007 SHALL have port cin (input, 1): carry-in when adding, borrow-in when subtracting.
REQ-008 SHALL have port sub (input, 1): 0 selects add, 1 selects subtract.
REQ-009 SHALL have ports out_valid (output, 1) and out_ready (input, 1): the downstream handshake.
REQ-010 SHALL have ports sum (output, N) and carry (output, 1): the result and carry-out.

Function
REQ-011 SHALL compute sum/carry = a + b + cin when sub=0, and a + ~b + ~cin when sub=1 (a - b - cin; carry=1 means no borrow).
REQ-012 SHALL split the add into STAGES slices of N/STAGES bits each; slice k SHALL be computed in stage k, taking the carry registered by stage k-1.
REQ-013 SHALL skew operands: unconsumed higher slices (b already conditionally inverted) SHALL travel with the transaction; completed lower sum bits SHALL be carried forward.
REQ-014 SHALL capture a transaction when in_valid && in_ready, and present it on out_valid/sum/carry exactly STAGES cycles later when there is no stall.
REQ-015 SHALL define advance = !out_valid || out_ready; every stage SHALL load from its predecessor only when advance=1, and SHALL hold otherwise.
REQ-016 SHALL drive in_ready = advance, combinationally.
REQ-017 SHALL hold sum, carry and out_valid stable while out_valid=1 and out_ready=0.
REQ-018 SHALL sustain one transaction per cycle with out_ready held high; an empty stage is a bubble (valid=0) and bubbles are not compacted.
REQ-019 SHALL deliver results in strict input order, with no loss or duplication under any in_valid/out_ready pattern.
REQ-020 SHALL produce sum and carry as pure functions of the registered stage contents; there SHALL be no combinational path from a, b, cin or sub to any output.

Reset
REQ-021 SHALL, while rst_n=0, clear all stage valid bits, data and carry registers to 0, which forces out_valid=0, sum=0 and carry=0 (overflow=0 when present).
REQ-022 SHALL discard all in-flight transactions on reset asserted mid-operation; the first output after release SHALL come from the first input captured after release.
REQ-023 SHALL accept input on the first rising clk edge after rst_n rises (in_ready=1, since out_valid=0).

Configuration
REQ-024 SHALL, when macro PIPE_ADDER_OVERFLOW_EN is defined, add output port overflow (1 bit): signed overflow = carry into the MSB XOR carry-out, pipelined with and aligned to sum.
REQ-025 SHALL, without PIPE_ADDER_OVERFLOW_EN, have no overflow port and no overflow logic; all other behaviour is identical.

Structure
REQ-026 SHALL place the mode constants (MODE_ADD=0, MODE_SUB=1) and the slice-width function (N/STAGES) in the shared package pipe_adder_pkg.
REQ-027 SHALL implement each slice as one instance of sub-module adder_slice: a combinational SLICE-bit ripple adder with inputs a, b, c and outputs sum, carry. All registers SHALL stay in pipe_adder_nb.
REQ-028 SHALL check parameter legality at elaboration and abort on an illegal N/STAGES combination.

Verification (N=16, STAGES=4 unless stated)
REQ-029 SHALL cover: a=0xFFFF, b=0x0001, cin=0, sub=0 -> sum=0x0000, carry=1, with out_valid rising exactly 4 cycles after capture.
REQ-030 SHALL cover: a=0x0005, b=0x0007, cin=0, sub=1 -> sum=0xFFFE, carry=0; and a=0x0007, b=0x0005, cin=1, sub=1 -> sum=0x0001, carry=1.
REQ-031 SHALL cover: 8 back-to-back inputs i=0..7 (a=i, b=0x0100), with out_ready low for cycles 5-7 -> in_ready low during the stall, outputs 0x0100..0x0107 in order, and no drops or duplicates.
REQ-032 SHALL cover: rst_n pulsed low for 1 cycle with 3 transactions in flight -> out_valid=0 immediately; the next output is the first post-reset input.
REQ-033 SHALL cover: with PIPE_ADDER_OVERFLOW_EN, a=0x7FFF, b=0x0001 add -> overflow=1; a=0x8000, b=0x0001 subtract -> overflow=1; a=0x0001, b=0x0001 add -> overflow=0.
REQ-034 SHALL cover: N=8, STAGES=1, a=0xF0, b=0x0F, cin=1 -> sum=0x00, carry=1, with latency 1 cycle.

Source files
------------

// File: rtl/pipe_adder_pkg.sv
// Shared constants and width helpers for the skewed pipelined adder.
// Optional overflow output is enabled with PIPE_ADDER_OVERFLOW_EN.
package pipe_adder_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    function automatic int slice_w(input int n, input int s);
        return (s > 0) ? n / s : 1;
    endfunction

    // Operand bits still unconsumed after stage k has done its slice.
    function automatic int rem_w(input int n, input int s, input int k);
        return n - (k + 1) * slice_w(n, s);
    endfunction

    // Stage k payload is {b_rem, a_rem, sum_done}; offsets pack all stages into one vector.
    function automatic int pay_off(input int n, input int s, input int k);
        int o;
        o = 0;
        for (int j = 0; j < k; j++) o += n + rem_w(n, s, j);
        return o;
    endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational W-bit ripple-carry adder used for one pipeline slice.
module adder_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c,
    output logic [W-1:0] sum,
    output logic         carry
);

    logic [W:0] cc;

    assign cc[0] = c;

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign sum[i]   = a[i] ^ b[i] ^ cc[i];
        assign cc[i+1]  = (a[i] & b[i]) | (cc[i] & (a[i] ^ b[i]));
    end

    assign carry = cc[W];

endmodule

// File: rtl/pipe_adder_nb.sv
// Skewed STAGES-deep add/subtract pipeline with a stall-all valid/ready handshake.
// Define PIPE_ADDER_OVERFLOW_EN to add the aligned signed-overflow output.
module pipe_adder_nb
    import pipe_adder_pkg::*;
#(
    parameter int N      = 16,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         carry
`ifdef PIPE_ADDER_OVERFLOW_EN
    ,
    output logic         overflow
`endif
);

    localparam int SW       = slice_w(N, STAGES);
    localparam int TOT      = pay_off(N, STAGES, STAGES);
    localparam int OFF_LAST = pay_off(N, STAGES, STAGES - 1);

    if (STAGES < 1 || STAGES > N || (N % STAGES) != 0) begin : g_bad_cfg
        $fatal(1, "pipe_adder_nb: illegal N=%0d STAGES=%0d", N, STAGES);
    end

    logic [STAGES:0]   vld_pipe;
    logic [STAGES:0]   c_pipe;
    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] c_q;
    logic [STAGES-1:0] c_d;
    logic [TOT-1:0]    pay_q;
    logic [TOT-1:0]    pay_d;
    logic              advance;

    // Subtract is a + ~b + ~cin; inversion happens once at entry and travels with b.
    assign vld_pipe[0]        = in_valid;
    assign vld_pipe[STAGES:1] = vld_q;
    assign c_pipe[0]          = (sub == MODE_SUB) ? ~cin : cin;
    assign c_pipe[STAGES:1]   = c_q;

    assign advance  = !vld_pipe[STAGES] || out_ready;
    assign in_ready = advance;

`ifdef PIPE_ADDER_OVERFLOW_EN
    logic ov_d;
    logic ov_q;
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int REM = rem_w(N, STAGES, k);
        localparam int OFF = pay_off(N, STAGES, k);
        localparam int PW  = N + REM;

        logic [SW-1:0] sa;
        logic [SW-1:0] sb;
        logic [SW-1:0] ss;
        logic          co;

        if (k == 0) begin : g_first
            logic [N-1:0] b_eff;
            assign b_eff = (sub == MODE_SUB) ? ~b : b;
            assign sa    = a[SW-1:0];
            assign sb    = b_eff[SW-1:0];
            if (REM > 0) begin : g_rem
                assign pay_d[OFF +: PW] = {b_eff[N-1:SW], a[N-1:SW], ss};
            end else begin : g_norem
                assign pay_d[OFF +: PW] = ss;
            end
        end else begin : g_next
            localparam int POFF = pay_off(N, STAGES, k - 1);
            localparam int DONE = k * SW;
            localparam int PPW  = N + REM + SW;
            logic [PPW-1:0] prev;
            assign prev = pay_q[POFF +: PPW];
            assign sa   = prev[DONE +: SW];
            assign sb   = prev[N +: SW];
            if (REM > 0) begin : g_rem
                assign pay_d[OFF +: PW] = {prev[N+SW +: REM], prev[DONE+SW +: REM],
                                           ss, prev[DONE-1:0]};
            end else begin : g_norem
                assign pay_d[OFF +: PW] = {ss, prev[DONE-1:0]};
            end
        end

        adder_slice #(.W(SW)) u_slice (
            .a     (sa),
            .b     (sb),
            .c     (c_pipe[k]),
            .sum   (ss),
            .carry (co)
        );

        assign c_d[k] = co;

`ifdef PIPE_ADDER_OVERFLOW_EN
        // Carry into the MSB is recovered from the MSB sum bit of the top slice.
        if (k == STAGES - 1) begin : g_ov
            assign ov_d = sa[SW-1] ^ sb[SW-1] ^ ss[SW-1] ^ co;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            c_q   <= '0;
            pay_q <= '0;
`ifdef PIPE_ADDER_OVERFLOW_EN
            ov_q  <= 1'b0;
`endif
        end else if (advance) begin
            vld_q <= vld_pipe[STAGES-1:0];
            c_q   <= c_d;
            pay_q <= pay_d;
`ifdef PIPE_ADDER_OVERFLOW_EN
            ov_q  <= ov_d;
`endif
        end
    end

    assign out_valid = vld_pipe[STAGES];
    assign sum       = pay_q[OFF_LAST +: N];
    assign carry     = c_pipe[STAGES];
`ifdef PIPE_ADDER_OVERFLOW_EN
    assign overflow  = ov_q;
`endif

endmodule
